pio_input_edge_irq: RTL and testbench

Parametrised Avalon-MM input PIO slave for the Nios II Qsys system. It samples a DATA_WIDTH-bit input port through a synchroniser and latches per-bit edge events in a write-1-to-clear capture register. A maskable level interrupt is raised from any captured edge. It is the successor to the fixed 8-bit polled input PIO, adding configurable width, metastability protection, edge capture and an IRQ.

---
 rtl/pio_input_edge_irq.sv | 122 ++++++++++++
 tb/tb_pio_input_edge_irq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_input_edge_irq.sv
// pio_input_edge_irq
//   Avalon-MM input PIO slave. It synchronises an external input port,
//   detects per-bit edges, and latches them in a write-1-to-clear capture
//   register. A maskable level interrupt is raised from any captured edge.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register select (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  slave select
//   write_n     write strobe, active-low
//   writedata   write data; only the low DATA_WIDTH bits are used
//   readdata    registered read data, zero-extended above DATA_WIDTH
//   in_port     asynchronous external inputs
//   irq         level interrupt, active-high
module pio_input_edge_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [2:0]            arm_q, arm_d;
  logic [31:0]           readdata_q, readdata_d;

  logic [DATA_WIDTH-1:0] sync_out;
  logic [DATA_WIDTH-1:0] edge_raw;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr;
  logic                  armed;
  logic                  wr;

  // Upper writedata bits are intentionally ignored for narrow ports.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_q == ARM_MAX);
  assign wr       = chipselect & ~write_n;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_out;
  end

  // The arm counter hides the bogus edges that appear while the freshly
  // reset sync chain and prev register fill with the real input levels.
  always_comb begin
    arm_d = armed ? arm_q : arm_q + 3'd1;
  end

  always_comb begin
    if (EDGE_TYPE == 1) begin
      edge_raw = ~sync_out & prev_q;
    end else if (EDGE_TYPE == 2) begin
      edge_raw = sync_out ^ prev_q;
    end else begin
      edge_raw = sync_out & ~prev_q;
    end
    edge_det = armed ? edge_raw : '0;
  end

  // Set has priority over a simultaneous write-1-to-clear.
  always_comb begin
    clr       = (wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr) | edge_det;
    irqmask_d = (wr && address == 2'd2) ? writedata[DATA_WIDTH-1:0] : irqmask_q;
  end

  // Read mux samples pre-write state, so a read of edgecapture that
  // coincides with a clear returns the value before the clear.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(sync_out);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      arm_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      arm_q      <= arm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_input_edge_irq.sv
module tb_pio_input_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1;
  logic [31:0] in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  logic [31:0] rd_a [3];
  logic        irq_a [3];
  assign rd_a[0] = rd0;
  assign rd_a[1] = rd1;
  assign rd_a[2] = rd2;
  assign irq_a[0] = irq0;
  assign irq_a[1] = irq1;
  assign irq_a[2] = irq2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pio_input_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));
  pio_input_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));
  pio_input_edge_irq #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

  // Reference model: h[d][k] is the input sampled k edges ago (k=0 newest,
  // zeros before reset release). sync_q equals the input SYNC edges old.
  int cw [3] = '{8, 8, 32};
  int cs [3] = '{2, 3, 2};
  int ce [3] = '{0, 1, 2};
  logic [31:0] h [3][5];
  logic [31:0] m_cap [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_rd [3];
  int          m_n [3];

  function automatic logic [31:0] wmask(int d);
    return (cw[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[d]) - 32'd1);
  endfunction

  function automatic logic model_irq(int d);
    return |(m_cap[d] & m_mask[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 5; k++) h[d][k] = '0;
      m_cap[d] = '0; m_mask[d] = '0; m_rd[d] = '0; m_n[d] = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] inv [3];
    logic [31:0] cur, old, ed, clr;
    logic        wr;
    inv[0] = 32'(in0); inv[1] = 32'(in1); inv[2] = in2;
    wr = chipselect && !write_n;
    for (int d = 0; d < 3; d++) begin
      for (int k = 4; k > 0; k--) h[d][k] = h[d][k-1];
      h[d][0] = inv[d] & wmask(d);
      m_n[d]++;
      cur = h[d][cs[d]];
      old = h[d][cs[d]+1];
      case (ce[d])
        0:       ed = cur & ~old;
        1:       ed = ~cur & old;
        default: ed = cur ^ old;
      endcase
      ed &= wmask(d);
      if (m_n[d] < cs[d] + 2) ed = '0;
      case (address)
        2'd0:    m_rd[d] = cur;
        2'd2:    m_rd[d] = m_mask[d];
        2'd3:    m_rd[d] = m_cap[d];
        default: m_rd[d] = '0;
      endcase
      clr = (wr && address == 2'd3) ? (writedata & wmask(d)) : '0;
      m_cap[d] = (m_cap[d] & ~clr) | ed;
      if (wr && address == 2'd2) m_mask[d] = writedata & wmask(d);
    end
  endtask

  task automatic step();
    if (reset_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle(input logic [1:0] a);
    chipselect = 1'b0; write_n = 1'b1; address = a; writedata = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = wd;
  endtask

  task automatic test_reset();
    in0 = 8'hFF; in1 = 8'hFF; in2 = 32'hFFFF_FFFF;
    bus_idle(2'd0);
    reset_n = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0)
      $display("FAIL reset_hold rd0=%h irq0=%b expected 0/0", rd0, irq0);
    else passes++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      address = (i % 2 == 1) ? 2'd3 : 2'd0;
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (rd_a[d] !== m_rd[d] || irq_a[d] !== model_irq(d))
          $display("FAIL reset_release dut%0d cyc%0d rd=%h irq=%b expected %h/%b",
                   d, i, rd_a[d], irq_a[d], m_rd[d], model_irq(d));
        else passes++;
      end
      checks++;
      if (irq0 !== 1'b0 || (address == 2'd3 && rd0 !== 32'h0))
        $display("FAIL reset_no_spurious cyc%0d rd0=%h irq0=%b expected 0", i, rd0, irq0);
      else passes++;
    end
    address = 2'd0;
    step();
    checks++;
    if (rd0 !== 32'h0000_00FF)
      $display("FAIL reset_data rd0=%h expected 000000ff", rd0);
    else passes++;
  endtask

  task automatic test_capture_irq();
    in0 = 8'h00;
    bus_idle(2'd0);
    repeat (4) step();
    bus_write(2'd3, 32'hFFFF_FFFF); step();
    bus_write(2'd2, 32'h4); step();
    bus_idle(2'd3);
    in0 = 8'h05;
    step();
    step();
    checks++;
    if (irq0 !== 1'b0) $display("FAIL cap_early irq0=%b expected 0", irq0);
    else passes++;
    step();
    checks++;
    if (irq0 !== 1'b1) $display("FAIL cap_irq irq0=%b expected 1", irq0);
    else passes++;
    step();
    checks++;
    if (rd0 !== 32'h05) $display("FAIL cap_read rd0=%h expected 00000005", rd0);
    else passes++;
    bus_write(2'd3, 32'h4); step();
    checks++;
    if (irq0 !== 1'b0) $display("FAIL cap_clear_irq irq0=%b expected 0", irq0);
    else passes++;
    bus_idle(2'd3); step();
    checks++;
    if (rd0 !== 32'h01 || rd0 !== m_rd[0])
      $display("FAIL cap_after_clear rd0=%h expected 00000001", rd0);
    else passes++;
  endtask

  task automatic test_collision();
    in0 = 8'h00;
    bus_idle(2'd0);
    repeat (4) step();
    bus_write(2'd3, 32'hFFFF_FFFF); step();
    bus_idle(2'd3);
    in0 = 8'h02;
    repeat (4) step();
    in0 = 8'h03;
    step();
    step();
    bus_write(2'd3, 32'h3); step();
    checks++;
    if (rd0 !== 32'h02) $display("FAIL collide_preread rd0=%h expected 00000002", rd0);
    else passes++;
    bus_idle(2'd3); step();
    checks++;
    if (rd0 !== 32'h01 || rd0 !== m_rd[0])
      $display("FAIL collide_setwins rd0=%h expected 00000001", rd0);
    else passes++;
  endtask

  task automatic test_edge_types();
    in1 = 8'h08; in2 = 32'h8;
    bus_idle(2'd0);
    repeat (6) step();
    bus_write(2'd3, 32'hFFFF_FFFF); step();
    bus_idle(2'd3);
    in1 = 8'h00; in2 = 32'h0;
    repeat (6) step();
    step();
    checks++;
    if (rd1 !== 32'h08) $display("FAIL falling_cap rd1=%h expected 00000008", rd1);
    else passes++;
    checks++;
    if (rd2 !== 32'h08) $display("FAIL any_fall_cap rd2=%h expected 00000008", rd2);
    else passes++;
    bus_write(2'd3, 32'hFFFF_FFFF); step();
    bus_idle(2'd3);
    in1 = 8'h08; in2 = 32'h8;
    repeat (6) step();
    step();
    checks++;
    if (rd1 !== 32'h00) $display("FAIL falling_ignores_rise rd1=%h expected 00000000", rd1);
    else passes++;
    checks++;
    if (rd2 !== 32'h08) $display("FAIL any_rise_cap rd2=%h expected 00000008", rd2);
    else passes++;
  endtask

  task automatic test_wide_regs();
    in2 = 32'hDEAD_BEEF;
    bus_write(2'd2, 32'hFFFF_FFFF); step();
    bus_idle(2'd2); step();
    checks++;
    if (rd2 !== 32'hFFFF_FFFF) $display("FAIL wide_mask rd2=%h expected ffffffff", rd2);
    else passes++;
    checks++;
    if (rd0 !== 32'h0000_00FF) $display("FAIL narrow_mask rd0=%h expected 000000ff", rd0);
    else passes++;
    bus_write(2'd1, 32'hFFFF_FFFF); step();
    bus_idle(2'd1); step();
    checks++;
    if (rd2 !== 32'h0) $display("FAIL reserved rd2=%h expected 00000000", rd2);
    else passes++;
    bus_write(2'd0, 32'h0); step();
    bus_idle(2'd0); step(); step();
    checks++;
    if (rd2 !== 32'hDEAD_BEEF) $display("FAIL data_ro rd2=%h expected deadbeef", rd2);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in0 ^= 8'($urandom & $urandom & $urandom);
      in1 ^= 8'($urandom & $urandom & $urandom);
      in2 ^= $urandom & $urandom & $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (rd_a[d] !== m_rd[d] || irq_a[d] !== model_irq(d))
          $display("FAIL random dut%0d it%0d rd=%h irq=%b expected %h/%b",
                   d, i, rd_a[d], irq_a[d], m_rd[d], model_irq(d));
        else passes++;
      end
    end
  endtask

  task automatic test_async_reset();
    bus_write(2'd2, 32'hFFFF_FFFF); step();
    bus_idle(2'd3);
    in0 = 8'h00;
    repeat (4) step();
    in0 = 8'hFF;
    repeat (3) step();
    checks++;
    if (irq0 !== 1'b1 || irq0 !== model_irq(0))
      $display("FAIL pre_reset_irq irq0=%b expected 1", irq0);
    else passes++;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0 || rd2 !== 32'h0)
      $display("FAIL async_rd rd=%h/%h/%h expected 0", rd0, rd1, rd2);
    else passes++;
    checks++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0 || irq2 !== 1'b0)
      $display("FAIL async_irq irq=%b%b%b expected 000", irq0, irq1, irq2);
    else passes++;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    address = 2'd2; step();
    checks++;
    if (rd0 !== 32'h0) $display("FAIL reset_mask rd0=%h expected 00000000", rd0);
    else passes++;
    address = 2'd3; step();
    checks++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0)
      $display("FAIL reset_cap rd0=%h irq0=%b expected 0/0", rd0, irq0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_capture_irq();
    test_collision();
    test_edge_types();
    test_wide_regs();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
